// File: rtl/alert_handler_esc_receiver.sv
// alert_handler_esc_receiver
//
// Peripheral-side responder for the differential escalation protocol. The
// sender (the alert handler escalation timer) drives esc_p_i/esc_n_i. This
// block decodes a ping or an escalation from that pair, answers on
// resp_p_o/resp_n_o, drives the local escalation enable and keeps
// debug statistics.
//
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   esc_p_i     escalation differential, positive leg
//   esc_n_i     escalation differential, negative leg
//   clr_i       clears sigint_o, ping_cnt_o and esc_cyc_o
//   resp_p_o    response differential, positive leg (registered)
//   resp_n_o    response differential, negative leg (registered)
//   esc_en_o    escalation action enable (registered)
//   sigint_o    sticky signal-integrity error flag
//   ping_cnt_o  completed pings, saturating
//   esc_cyc_o   cycles spent in the most recent escalation, saturating
module alert_handler_esc_receiver #(
  parameter int unsigned PingCntDw = 16,
  parameter int unsigned EscCntDw  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 esc_p_i,
  input  logic                 esc_n_i,
  input  logic                 clr_i,
  output logic                 resp_p_o,
  output logic                 resp_n_o,
  output logic                 esc_en_o,
  output logic                 sigint_o,
  output logic [PingCntDw-1:0] ping_cnt_o,
  output logic [EscCntDw-1:0]  esc_cyc_o
);

  typedef enum logic [1:0] {
    Idle    = 2'b00,
    Check   = 2'b01,
    EscResp = 2'b10,
    SigInt  = 2'b11
  } state_e;

  state_e state_r, state_s;

  logic resp_p_r, resp_n_r, esc_en_r, sigint_r;
  logic resp_p_s, resp_n_s, esc_en_s;
  logic [PingCntDw-1:0] ping_cnt_r;
  logic [EscCntDw-1:0]  esc_cyc_r;

  logic sigint_s, esc_lvl_s;
  logic ping_inc_s, esc_zero_s, esc_load_s, esc_inc_s;

  // Differential decode: equal legs are a signal-integrity fault.
  assign sigint_s  = (esc_p_i == esc_n_i);
  assign esc_lvl_s = esc_p_i & ~sigint_s;

  // Next-state, next-response and counter-control decode.
  always_comb begin
    state_s    = state_r;
    resp_p_s   = 1'b0;
    resp_n_s   = 1'b1;
    esc_en_s   = 1'b0;
    ping_inc_s = 1'b0;
    esc_zero_s = 1'b0;
    esc_load_s = 1'b0;
    esc_inc_s  = 1'b0;

    case (state_r)
      Idle: begin
        if (esc_lvl_s) begin
          state_s    = Check;
          resp_p_s   = 1'b1;
          resp_n_s   = 1'b0;
          esc_zero_s = 1'b1;
        end else begin
          state_s = Idle;
        end
      end
      Check: begin
        if (esc_lvl_s) begin
          state_s    = EscResp;
          esc_en_s   = 1'b1;
          esc_load_s = 1'b1;
        end else begin
          state_s    = Idle;
          ping_inc_s = 1'b1;
        end
      end
      EscResp: begin
        if (esc_lvl_s) begin
          state_s   = EscResp;
          resp_p_s  = ~resp_p_r;
          resp_n_s  = resp_p_r;
          esc_en_s  = 1'b1;
          esc_inc_s = 1'b1;
        end else begin
          state_s = Idle;
        end
      end
      SigInt: begin
        state_s = Idle;
      end
      default: begin
        state_s = Idle;
      end
    endcase

    // Integrity faults override every other transition; both response legs
    // toggle together so the sender also sees an integrity error.
    if (sigint_s) begin
      state_s    = SigInt;
      resp_p_s   = ~resp_p_r;
      resp_n_s   = ~resp_p_r;
      esc_en_s   = 1'b0;
      ping_inc_s = 1'b0;
      esc_zero_s = 1'b0;
      esc_load_s = 1'b0;
      esc_inc_s  = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // FSM state and registered response/enable outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r  <= Idle;
      resp_p_r <= 1'b0;
      resp_n_r <= 1'b1;
      esc_en_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      resp_p_r <= resp_p_s;
      resp_n_r <= resp_n_s;
      esc_en_r <= esc_en_s;
    end
  end

  // Sticky integrity flag; a same-cycle detection beats the clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sigint_r <= 1'b0;
    end else if (sigint_s) begin
      sigint_r <= 1'b1;
    end else if (clr_i) begin
      sigint_r <= 1'b0;
    end else begin
      sigint_r <= sigint_r;
    end
  end

  // Saturating ping counter; clear beats a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ping_cnt_r <= '0;
    end else if (clr_i) begin
      ping_cnt_r <= '0;
    end else if (ping_inc_s && !(&ping_cnt_r)) begin
      ping_cnt_r <= ping_cnt_r + PingCntDw'(1);
    end else begin
      ping_cnt_r <= ping_cnt_r;
    end
  end

  // Saturating escalation-duration counter; holds after escalation ends.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      esc_cyc_r <= '0;
    end else if (clr_i || esc_zero_s) begin
      esc_cyc_r <= '0;
    end else if (esc_load_s) begin
      esc_cyc_r <= EscCntDw'(1);
    end else if (esc_inc_s && !(&esc_cyc_r)) begin
      esc_cyc_r <= esc_cyc_r + EscCntDw'(1);
    end else begin
      esc_cyc_r <= esc_cyc_r;
    end
  end

  assign resp_p_o   = resp_p_r;
  assign resp_n_o   = resp_n_r;
  assign esc_en_o   = esc_en_r;
  assign sigint_o   = sigint_r;
  assign ping_cnt_o = ping_cnt_r;
  assign esc_cyc_o  = esc_cyc_r;

endmodule

// File: tb/tb_alert_handler_esc_receiver.sv
module tb_alert_handler_esc_receiver;

  localparam int unsigned PingCntDw = 2;
  localparam int unsigned EscCntDw  = 4;

  logic clk;
  logic rst_n;
  logic esc_p, esc_n, clr;
  logic resp_p, resp_n, esc_en, sigint;
  logic [PingCntDw-1:0] ping_cnt;
  logic [EscCntDw-1:0]  esc_cyc;

  int total = 0;
  int bad   = 0;

  alert_handler_esc_receiver #(
    .PingCntDw(PingCntDw),
    .EscCntDw (EscCntDw)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .esc_p_i   (esc_p),
    .esc_n_i   (esc_n),
    .clr_i     (clr),
    .resp_p_o  (resp_p),
    .resp_n_o  (resp_n),
    .esc_en_o  (esc_en),
    .sigint_o  (sigint),
    .ping_cnt_o(ping_cnt),
    .esc_cyc_o (esc_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // new inputs are driven at that same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic n);
    esc_p = p;
    esc_n = n;
  endtask

  task automatic chk_resp(input string tag, input logic p, input logic n, input logic en);
    chk({tag, "_resp_p"}, 32'(resp_p), 32'(p));
    chk({tag, "_resp_n"}, 32'(resp_n), 32'(n));
    chk({tag, "_esc_en"}, 32'(esc_en), 32'(en));
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(1'b0, 1'b1);
    step();
    step();
    // Reset state
    chk_resp("rst", 1'b0, 1'b1, 1'b0);
    chk("rst_sigint", 32'(sigint), 32'd0);
    chk("rst_ping", 32'(ping_cnt), 32'd0);
    chk("rst_esccyc", 32'(esc_cyc), 32'd0);
    rst_n = 1'b1;
    step();

    // Ping: one cycle of 1/0 then 0/1
    drive(1'b1, 1'b0);
    step();
    chk_resp("ping_t1", 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1);
    step();
    chk_resp("ping_t2", 1'b0, 1'b1, 1'b0);
    chk("ping_cnt1", 32'(ping_cnt), 32'd1);
    step();
    chk_resp("ping_t3", 1'b0, 1'b1, 1'b0);

    // Escalation: 10 cycles of 1/0
    drive(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_resp("esc_run", (i % 2 == 0), (i % 2 != 0), (i >= 1));
      chk("esc_run_cyc", 32'(esc_cyc), 32'(i));
    end
    drive(1'b0, 1'b1);
    step();
    chk_resp("esc_end", 1'b0, 1'b1, 1'b0);
    chk("esc_end_cyc", 32'(esc_cyc), 32'd9);
    step();
    chk("esc_hold_cyc", 32'(esc_cyc), 32'd9);
    chk("esc_sigint", 32'(sigint), 32'd0);

    // Integrity fault from Idle: both legs high for 3 cycles
    drive(1'b1, 1'b1);
    step();
    chk_resp("sig_t1", 1'b1, 1'b1, 1'b0);
    chk("sig_flag", 32'(sigint), 32'd1);
    step();
    chk_resp("sig_t2", 1'b0, 1'b0, 1'b0);
    step();
    chk_resp("sig_t3", 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1);
    step();
    chk_resp("sig_exit", 1'b0, 1'b1, 1'b0);
    chk("sig_sticky1", 32'(sigint), 32'd1);
    step();
    chk("sig_sticky2", 32'(sigint), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sig_clr", 32'(sigint), 32'd0);
    chk("clr_ping", 32'(ping_cnt), 32'd0);
    chk("clr_esccyc", 32'(esc_cyc), 32'd0);

    // Clear and detection in the same cycle: detection wins
    drive(1'b1, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sig_clr_race", 32'(sigint), 32'd1);
    drive(1'b0, 1'b1);
    step();
    chk_resp("sig_race_exit", 1'b0, 1'b1, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sig_clr2", 32'(sigint), 32'd0);

    // Fault in the middle of an escalation
    drive(1'b1, 1'b0);
    step();
    step();
    step();
    chk_resp("mid_pre", 1'b1, 1'b0, 1'b1);
    chk("mid_pre_cyc", 32'(esc_cyc), 32'd2);
    drive(1'b0, 1'b0);
    step();
    chk_resp("mid_fault", 1'b0, 1'b0, 1'b0);
    chk("mid_fault_flag", 32'(sigint), 32'd1);
    chk("mid_fault_cyc", 32'(esc_cyc), 32'd2);
    drive(1'b1, 1'b0);
    step();
    chk_resp("mid_idle", 1'b0, 1'b1, 1'b0);
    step();
    chk_resp("mid_check", 1'b1, 1'b0, 1'b0);
    chk("mid_check_cyc", 32'(esc_cyc), 32'd0);
    step();
    chk_resp("mid_reesc", 1'b0, 1'b1, 1'b1);
    chk("mid_reesc_cyc", 32'(esc_cyc), 32'd1);
    drive(1'b0, 1'b1);
    step();
    chk_resp("mid_done", 1'b0, 1'b1, 1'b0);
    chk("mid_done_cyc", 32'(esc_cyc), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("mid_clr_flag", 32'(sigint), 32'd0);

    // Ping counter saturation at 3 with a 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0);
      step();
      drive(1'b0, 1'b1);
      step();
      chk("ping_sat", 32'(ping_cnt), 32'((k > 3) ? 3 : k));
    end
    // Clear on the same cycle as a ping completion
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ping_clr_race", 32'(ping_cnt), 32'd0);

    // Escalation counter saturation at 15 with a 4-bit counter
    drive(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
    end
    chk("esc_sat", 32'(esc_cyc), 32'd15);
    chk_resp("esc_sat_resp", 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1);
    step();
    chk("esc_sat_hold", 32'(esc_cyc), 32'd15);

    // Reset in the middle of an escalation
    drive(1'b1, 1'b1);
    step();
    drive(1'b1, 1'b0);
    step();
    step();
    step();
    step();
    chk("rstmid_pre_en", 32'(esc_en), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_resp("rstmid", 1'b0, 1'b1, 1'b0);
    chk("rstmid_sigint", 32'(sigint), 32'd0);
    chk("rstmid_ping", 32'(ping_cnt), 32'd0);
    chk("rstmid_cyc", 32'(esc_cyc), 32'd0);
    drive(1'b0, 1'b1);
    step();
    chk_resp("post_rst", 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alert_handler_esc_receiver.md
Name: alert_handler_esc_receiver

Overview:
- Peripheral-side responder for the differential escalation protocol whose sender is driven by the alert handler's escalation timer (one instance per escalation severity).
- Decodes ping vs. escalation from the differential pair esc_p/esc_n and answers on the differential pair resp_p/resp_n.
- Asserts the local escalation enable, flags signal-integrity faults, and keeps ping and escalation statistics for debug readout.

Parameters:
- PingCntDw, 16, width of the saturating ping counter.
- EscCntDw, 32, width of the saturating escalation-duration counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- esc_p_i  in  1  escalation differential, positive leg (same clock domain as the sender).
- esc_n_i  in  1  escalation differential, negative leg.
- clr_i  in  1  clears sigint_o, ping_cnt_o and esc_cyc_o.
- resp_p_o  out  1  response differential, positive leg (registered).
- resp_n_o  out  1  response differential, negative leg (registered).
- esc_en_o  out  1  escalation action enable to the local peripheral (registered).
- sigint_o  out  1  sticky signal-integrity error flag.
- ping_cnt_o  out  PingCntDw  completed pings, saturating.
- esc_cyc_o  out  EscCntDw  cycles spent in the most recent escalation, saturating.

Behaviour:
- Reset (rst_ni low at a clock edge) forces all state to reset values on the next cycle, including mid-escalation:
  - state = Idle; resp_p_o = 0; resp_n_o = 1; esc_en_o = 0; sigint_o = 0; both counters = 0.
- Input decode is combinational on the current-cycle inputs:
  - sigint = (esc_p_i == esc_n_i).
  - esc_lvl = esc_p_i when sigint is low.
- All outputs are registered: inputs in cycle t determine state and outputs in cycle t+1.
- FSM states: Idle, Check, EscResp, SigInt. sigint has priority over every transition below.
  - Any state, sigint = 1: go to SigInt.
    - resp_p = resp_n = ~resp_p(previous); the first SigInt cycle after Idle gives 1/1.
    - esc_en = 0; sigint_o set.
  - SigInt, sigint = 0: go to Idle; resp = 0/1.
  - Idle: resp = 0/1.
    - If esc_lvl = 1: go to Check; resp = 1/0; esc_cyc cleared to 0.
  - Check, esc_lvl = 0 (ping): go to Idle; resp = 0/1; ping_cnt += 1.
  - Check, esc_lvl = 1 (escalation): go to EscResp; resp = 0/1; esc_en = 1; esc_cyc = 1.
  - EscResp, esc_lvl = 1: stay; resp_p toggles each cycle (resp_n = ~resp_p); esc_en = 1; esc_cyc += 1.
  - EscResp, esc_lvl = 0: go to Idle; resp = 0/1; esc_en = 0; esc_cyc holds its value.
  - Illegal state encoding: go to Idle with reset-value outputs.
- resp_n_o == ~resp_p_o in every state except SigInt.
- Counters saturate at all-ones and never wrap.
- clr_i:
  - Zeroes ping_cnt_o and esc_cyc_o next cycle; clr wins over a same-cycle increment.
  - Clears sigint_o, but a same-cycle sigint detection wins (flag stays 1).
  - Has no effect on the FSM or esc_en_o.
- A ping response is exactly 2 cycles: resp_p = 1, 0.
- Escalation latency: esc_en_o rises 2 cycles after esc_p_i rises and falls 1 cycle after esc_p_i falls.

Test Plan:
- Ping: esc_p/n = 1/0 for 1 cycle at t0, then 0/1 -> resp_p = 1 at t0+1, 0 at t0+2 and after; esc_en_o never 1; ping_cnt_o = 1.
- Escalation: esc_p = 1 for cycles t0..t0+9 -> resp_p = 1,0,1,0,… from t0+1; esc_en_o = 1 for t0+2..t0+10 and 0 at t0+11; esc_cyc_o = 9 and held afterwards.
- Integrity fault: esc_p = esc_n = 1 for 3 cycles from Idle -> resp_p = resp_n = 1,0,1 at t0+1..t0+3; sigint_o = 1; then 0/1 -> Idle with resp 0/1; sigint_o stays 1 until clr_i pulses.
- Fault mid-escalation: esc_p = esc_n = 0 during EscResp -> esc_en_o = 0 next cycle; FSM enters SigInt; returning to 1/0 re-enters via Idle -> Check -> EscResp with esc_cyc restarting at 1.
- Saturation and clear: PingCntDw = 2 with 5 pings -> ping_cnt_o = 3; clr_i asserted with a same-cycle ping completion -> ping_cnt_o = 0.
- Reset mid-escalation: rst_ni low for 1 cycle while in EscResp -> next cycle resp = 0/1, esc_en_o = 0, counters = 0, sigint_o = 0.
